// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester BRAM port arbiter:
// grant states, requester count and an index helper.
package bram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Index of the competing requester
    function automatic logic other(input logic k);
        return ~k;
    endfunction

endpackage

// File: rtl/bram_arb_burst_counter.sv
// Burst length counter for the current port owner.
// Clears on ownership change, saturates at MAX_BURST-1.
module bram_arb_burst_counter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_limit;

    assign w_limit = (r_cnt == LIMIT);
    assign o_cnt   = r_cnt;
    assign o_limit = w_limit;

    // Count issued accesses; hold at the limit so long bursts never wrap
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbiter sharing one single-port BRAM between host loader (0) and
// accumulate engine (1). Optional macro: ARB_FIXED_PRIO_EN.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] we_i,
    input  logic [AWIDTH-1:0]  addr0_i,
    input  logic [AWIDTH-1:0]  addr1_i,
    input  logic [DWIDTH-1:0]  d0_i,
    input  logic [DWIDTH-1:0]  d1_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [NUM_REQ-1:0] rvalid_o,
    output logic [DWIDTH-1:0]  q_o,
    output logic               busy_o,
    output logic [AWIDTH-1:0]  addr_o,
    output logic               ce_o,
    output logic               we_o,
    output logic [DWIDTH-1:0]  d_o,
    input  logic [DWIDTH-1:0]  q_i
);

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_last_owner;
    logic [NUM_REQ-1:0] r_rvalid;

    logic               w_own_vld;
    logic               w_owner;
    logic               w_req_own;
    logic               w_req_oth;
    logic               w_issue;
    logic               w_rd_issue;
    logic               w_can_preempt;
    logic               w_release;
    logic               w_clr;
    logic               w_limit;
    logic [CNT_W-1:0]   w_cnt;
    state_t             w_oth_st;
    state_t             w_tie_st;

    assign w_own_vld  = (r_state != ST_IDLE);
    assign w_owner    = (r_state == ST_OWN1);
    assign w_req_own  = req_i[w_owner];
    assign w_req_oth  = req_i[other(w_owner)];
    assign w_issue    = w_own_vld && w_req_own;
    assign w_rd_issue = w_issue && !we_i[w_owner];
    assign w_oth_st   = w_owner ? ST_OWN0 : ST_OWN1;

`ifdef ARB_FIXED_PRIO_EN
    // Host loader always wins ties and is never cut short
    assign w_tie_st      = ST_OWN0;
    assign w_can_preempt = w_owner;
`else
    // Alternate ties; both requesters obey the burst limit
    assign w_tie_st      = r_last_owner ? ST_OWN0 : ST_OWN1;
    assign w_can_preempt = 1'b1;
`endif

    assign w_release = !w_req_own ||
                       (w_can_preempt && w_limit && w_issue && w_req_oth);

    assign w_clr = (w_state_nx != r_state);

    assign gnt_o    = {r_state == ST_OWN1, r_state == ST_OWN0};
    assign busy_o   = w_own_vld;
    assign rvalid_o = r_rvalid;
    assign q_o      = q_i;

    bram_arb_burst_counter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_en    (w_issue),
        .o_cnt   (w_cnt),
        .o_limit (w_limit)
    );

    // Grant state and last-owner register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            if (w_clr && w_state_nx != ST_IDLE) begin
                r_last_owner <= (w_state_nx == ST_OWN1);
            end
        end
    end

    // Next owner: grant from idle, hand off or drop on release
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_i == 2'b11) begin
                    w_state_nx = w_tie_st;
                end else if (req_i[0]) begin
                    w_state_nx = ST_OWN0;
                end else if (req_i[1]) begin
                    w_state_nx = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_release) begin
                    if (w_req_oth) begin
                        w_state_nx = w_oth_st;
                    end else if (!w_req_own) begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // BRAM port mux: owner's inputs, strobes only on an issued access
    always_comb begin
        addr_o = '0;
        d_o    = '0;
        ce_o   = 1'b0;
        we_o   = 1'b0;
        if (w_own_vld) begin
            addr_o = w_owner ? addr1_i : addr0_i;
            d_o    = w_owner ? d1_i : d0_i;
            ce_o   = w_issue;
            we_o   = w_issue && we_i[w_owner];
        end
    end

    // Read-return valid, one cycle behind the issuing read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= gnt_o & {NUM_REQ{w_rd_issue}};
        end
    end

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a BRAM model.
// Optional macro: ARB_FIXED_PRIO_EN.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_i, we_i;
    logic [7:0]  addr0_i, addr1_i;
    logic [31:0] d0_i, d1_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] q_o, d_o, q_i;
    logic        busy_o, ce_o, we_o;
    logic [7:0]  addr_o;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .DWIDTH    (32),
        .AWIDTH    (8),
        .MAX_BURST (4),
        .CNT_W     (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr0_i  (addr0_i),
        .addr1_i  (addr1_i),
        .d0_i     (d0_i),
        .d1_i     (d1_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .q_o      (q_o),
        .busy_o   (busy_o),
        .addr_o   (addr_o),
        .ce_o     (ce_o),
        .we_o     (we_o),
        .d_o      (d_o),
        .q_i      (q_i)
    );

    // Single-port BRAM, read latency 1
    always @(posedge clk) begin
        if (ce_o) begin
            if (we_o) mem[addr_o] <= d_o;
            else      q_i <= mem[addr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [1:0] exp_gnt [0:8];
    int issues;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5] = 32'hDEADBEEF;
        q_i = '0;
        reset = 1'b1; req_i = '0; we_i = '0;
        addr0_i = '0; addr1_i = '0; d0_i = '0; d1_i = '0;

        nxt();
        nxt(); #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ce", ce_o, 1'b0);
        chk("rst_rvalid", rvalid_o, 2'b00);

        // Single read of addr 5
        reset = 1'b0; req_i = 2'b01; addr0_i = 8'h05; #1;
        nxt(); #1;
        chk("rd_gnt", gnt_o, 2'b01);
        chk("rd_ce", ce_o, 1'b1);
        chk("rd_addr", addr_o, 8'h05);
        chk("rd_we", we_o, 1'b0);
        nxt(); #1;
        chk("rd_rvalid", rvalid_o, 2'b01);
        chk("rd_q", q_o, 32'hDEADBEEF);

        // Reset for 2 cycles while OWN0 reads
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0; req_i = 2'b11; addr1_i = 8'h06; #1;
        chk("rst2_gnt", gnt_o, 2'b00);
        chk("rst2_ce", ce_o, 1'b0);
        chk("rst2_rvalid", rvalid_o, 2'b00);

`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 9; i++) exp_gnt[i] = 2'b01;
`else
        for (int i = 0; i < 9; i++) exp_gnt[i] = (i >= 4 && i < 8) ? 2'b10 : 2'b01;
`endif
        for (int i = 0; i < 9; i++) begin
            nxt(); #1;
            chk($sformatf("arb_gnt%0d", i), gnt_o, exp_gnt[i]);
            chk($sformatf("arb_ce%0d", i), ce_o, 1'b1);
        end

`ifdef ARB_FIXED_PRIO_EN
        nxt();
        req_i = 2'b10; #1;
        chk("fp_dead_gnt", gnt_o, 2'b01);
        chk("fp_dead_ce", ce_o, 1'b0);
        nxt(); #1;
        chk("fp_hand_gnt", gnt_o, 2'b10);
`endif
        nxt();
        req_i = 2'b00; #1;
        chk("drop_ce", ce_o, 1'b0);
        nxt(); #1;
        chk("drop_gnt", gnt_o, 2'b00);
        chk("drop_busy", busy_o, 1'b0);

        // Requester 1 writes, then requester 0 reads it back
        req_i = 2'b10; we_i = 2'b10; addr1_i = 8'h10; d1_i = 32'h12345678; #1;
        nxt(); #1;
        chk("wr_gnt", gnt_o, 2'b10);
        chk("wr_ce", ce_o, 1'b1);
        chk("wr_we", we_o, 1'b1);
        chk("wr_addr", addr_o, 8'h10);
        chk("wr_d", d_o, 32'h12345678);
        nxt();
        req_i = 2'b00; we_i = 2'b00; #1;
        chk("wr_norv", rvalid_o, 2'b00);
        nxt();
        req_i = 2'b01; addr0_i = 8'h10; #1;
        chk("wr_norv2", rvalid_o, 2'b00);
        nxt(); #1;
        chk("rb_gnt", gnt_o, 2'b01);
        chk("rb_addr", addr_o, 8'h10);
        nxt();
        req_i = 2'b00; #1;
        chk("rb_rvalid", rvalid_o, 2'b01);
        chk("rb_q", q_o, 32'h12345678);
        nxt(); #1;
        chk("rb_rvalid_off", rvalid_o, 2'b00);

        // Uncontended requester-1 burst, then requester 0 competes
        req_i = 2'b10; addr1_i = 8'h20; #1;
        issues = 0;
        for (int i = 0; i < 40; i++) begin
            nxt(); #1;
            if (gnt_o == 2'b10 && ce_o) issues++;
        end
        chk("unc_issues", issues, 40);
        nxt();
        req_i = 2'b11; #1;
        chk("unc_last_gnt", gnt_o, 2'b10);
        chk("unc_last_ce", ce_o, 1'b1);
        nxt(); #1;
        chk("unc_hand_gnt", gnt_o, 2'b01);
        nxt();
        req_i = 2'b00;
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
